// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, T-state encodings
// and the packed control word that drives the rest of the bus machine.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  typedef struct packed {
    logic Cp;
    logic Ep;
    logic nLm;
    logic nCE;
    logic nLi;
    logic nEi;
    logic nLa;
    logic Ea;
    logic sub;
    logic Eu;
    logic nLb;
    logic nLo;
  } cw_t;

  // Every active-low strobe high, every active-high strobe low.
  localparam cw_t CW_IDLE = '{
    Cp: 1'b0, Ep: 1'b0, nLm: 1'b1, nCE: 1'b1, nLi: 1'b1, nEi: 1'b1,
    nLa: 1'b1, Ea: 1'b0, sub: 1'b0, Eu: 1'b0, nLb: 1'b1, nLo: 1'b1
  };

endpackage

// File: rtl/sap_ring_counter.sv
// Six-state one-hot T-state ring. Steps on advance, jumps back to T1 when
// restart accompanies advance, and wraps T6 -> T1 on its own.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       restart,
  output logic [5:0] t_state
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_state <= T1;
    end else if (advance) begin
      t_state <= restart ? T1 : {t_state[4:0], t_state[5]};
    end
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control unit: instruction register, halt flag and the microcode decode
// that turns (T-state, opcode) into the machine's control word.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int SKIP_IDLE = 1,
  parameter int OPW       = 4,
  parameter int ADW       = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [7:0]     bus_in,
  output logic [ADW-1:0] ir_operand,
  output logic [5:0]     t_state,
  output logic           Cp,
  output logic           Ep,
  output logic           nLm,
  output logic           nCE,
  output logic           nLi,
  output logic           nEi,
  output logic           nLa,
  output logic           Ea,
  output logic           sub,
  output logic           Eu,
  output logic           nLb,
  output logic           nLo,
  output logic           halted
);

  logic [OPW+ADW-1:0] ir;
  logic [OPW-1:0]     opcode;
  logic               active;
  logic               last_state;
  logic               hlt_now;
  logic               advance;
  cw_t                cw;
  cw_t                cw_out;

  assign opcode     = ir[OPW+ADW-1 -: OPW];
  assign ir_operand = ir[ADW-1:0];
  assign active     = run && !halted;
  assign advance    = active && !hlt_now;

  sap_ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .restart (last_state),
    .t_state (t_state)
  );

  // NOTE: the reset branch clears IR and halt synchronously; there is no
  // memory here, only two small registers, so everything gets a reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir     <= '0;
      halted <= 1'b0;
    end else if (active) begin
      if (t_state == T3) ir <= bus_in;
      if (hlt_now)       halted <= 1'b1;
    end
  end

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cw         = CW_IDLE;
    last_state = 1'b0;
    hlt_now    = 1'b0;
    unique case (t_state)
      T1: begin
        cw.Ep  = 1'b1;
        cw.nLm = 1'b0;
      end
      T2: cw.Cp = 1'b1;
      T3: begin
        cw.nCE = 1'b0;
        cw.nLi = 1'b0;
      end
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw.nLm = 1'b0;
            cw.nEi = 1'b0;
            cw.sub = (opcode == OP_SUB);
          end
          OP_OUT: begin
            cw.Ea      = 1'b1;
            cw.nLo     = 1'b0;
            last_state = (SKIP_IDLE != 0);
          end
          OP_HLT:  hlt_now    = 1'b1;
          default: last_state = (SKIP_IDLE != 0);
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA: begin
            cw.nCE     = 1'b0;
            cw.nLa     = 1'b0;
            last_state = (SKIP_IDLE != 0);
          end
          OP_ADD, OP_SUB: begin
            cw.nCE = 1'b0;
            cw.nLb = 1'b0;
            cw.sub = (opcode == OP_SUB);
          end
          default: ;
        endcase
      end
      T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw.Eu  = 1'b1;
          cw.nLa = 1'b0;
          cw.sub = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign cw_out = active ? cw : CW_IDLE;

  assign Cp  = cw_out.Cp;
  assign Ep  = cw_out.Ep;
  assign nLm = cw_out.nLm;
  assign nCE = cw_out.nCE;
  assign nLi = cw_out.nLi;
  assign nEi = cw_out.nEi;
  assign nLa = cw_out.nLa;
  assign Ea  = cw_out.Ea;
  assign sub = cw_out.sub;
  assign Eu  = cw_out.Eu;
  assign nLb = cw_out.nLb;
  assign nLo = cw_out.nLo;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboarded bench for sap_control_sequencer: directed instruction streams
// on a SKIP_IDLE=1 and a SKIP_IDLE=0 instance sharing clock and inputs.
module tb_sap_control_sequencer;
  import sap_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] bus_in;

  logic [3:0] opr1, opr0;
  logic [5:0] t1s, t0s;
  logic Cp1, Ep1, nLm1, nCE1, nLi1, nEi1, nLa1, Ea1, sub1, Eu1, nLb1, nLo1, hlt1;
  logic Cp0, Ep0, nLm0, nCE0, nLi0, nEi0, nLa0, Ea0, sub0, Eu0, nLb0, nLo0, hlt0;

  always #5 clk = ~clk;

  sap_control_sequencer #(.SKIP_IDLE(1)) dut_skip (
    .clk(clk), .rst(rst), .run(run), .bus_in(bus_in), .ir_operand(opr1),
    .t_state(t1s), .Cp(Cp1), .Ep(Ep1), .nLm(nLm1), .nCE(nCE1), .nLi(nLi1),
    .nEi(nEi1), .nLa(nLa1), .Ea(Ea1), .sub(sub1), .Eu(Eu1), .nLb(nLb1),
    .nLo(nLo1), .halted(hlt1)
  );

  sap_control_sequencer #(.SKIP_IDLE(0)) dut_full (
    .clk(clk), .rst(rst), .run(run), .bus_in(bus_in), .ir_operand(opr0),
    .t_state(t0s), .Cp(Cp0), .Ep(Ep0), .nLm(nLm0), .nCE(nCE0), .nLi(nLi0),
    .nEi(nEi0), .nLa(nLa0), .Ea(Ea0), .sub(sub0), .Eu(Eu0), .nLb(nLb0),
    .nLo(nLo0), .halted(hlt0)
  );

  typedef struct {
    string      name;
    bit         skip;
    logic [5:0] t;
    logic [3:0] opr;
    cw_t        cw;
    logic       hlt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic cw_t mk(input logic cp, ep, nlm, nce, nli, nei,
                             input logic nla, ea, sb, eu, nlb, nlo);
    return '{Cp: cp, Ep: ep, nLm: nlm, nCE: nce, nLi: nli, nEi: nei,
             nLa: nla, Ea: ea, sub: sb, Eu: eu, nLb: nlb, nLo: nlo};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Hand-written expected control words, one per distinct microstep.
  cw_t IDLE, F1, F2, F3, MEM4, SUB4, LDA5, ADD5, SUB5, ADD6, SUB6, OUT4;

  // Monitor: every cycle that has a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [22:0] got, want;
      e = q.pop_front();
      if (e.skip)
        got = {t1s, opr1, mk(Cp1, Ep1, nLm1, nCE1, nLi1, nEi1, nLa1, Ea1, sub1, Eu1, nLb1, nLo1), hlt1};
      else
        got = {t0s, opr0, mk(Cp0, Ep0, nLm0, nCE0, nLi0, nEi0, nLa0, Ea0, sub0, Eu0, nLb0, nLo0), hlt0};
      want = {e.t, e.opr, e.cw, e.hlt};
      check(e.name, {9'd0, got}, {9'd0, want});
    end
  end

  initial begin
    repeat (2000) @(posedge clk);
    check("wait_expired", 32'd1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected outputs of the current cycle, then move to the next.
  task automatic step(input string name, input bit skip, input logic [5:0] t,
                      input logic [7:0] ir, input cw_t cw, input logic hlt);
    exp_t e;
    e.name = name; e.skip = skip; e.t = t; e.opr = ir[3:0]; e.cw = cw; e.hlt = hlt;
    q.push_back(e);
    @(negedge clk);
    tick();
  endtask

  task automatic fetch(input bit skip, input logic [7:0] prev, input logic [7:0] nxt);
    step("fetch_t1", skip, T1, prev, F1, 1'b0);
    step("fetch_t2", skip, T2, prev, F2, 1'b0);
    bus_in = nxt;
    step("fetch_t3", skip, T3, prev, F3, 1'b0);
    bus_in = 8'h00;
  endtask

  initial begin
    IDLE = mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1);
    F1   = mk(0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1);
    F2   = mk(1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1);
    F3   = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    MEM4 = mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1);
    SUB4 = mk(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1);
    LDA5 = mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    ADD5 = mk(0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 1);
    SUB5 = mk(0, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 1);
    ADD6 = mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1);
    SUB6 = mk(0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1);
    OUT4 = mk(0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0);

    rst = 1'b1; run = 1'b0; bus_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    step("reset_idle", 1, T1, 8'h00, IDLE, 1'b0);

    // LDA 9 with SKIP_IDLE=1: T5 goes straight back to T1.
    run = 1'b1;
    fetch(1, 8'h00, 8'h09);
    step("lda_t4", 1, T4, 8'h09, MEM4, 1'b0);
    step("lda_t5", 1, T5, 8'h09, LDA5, 1'b0);

    // ADD A then SUB A: both always reach T6.
    fetch(1, 8'h09, 8'h1A);
    step("add_t4", 1, T4, 8'h1A, MEM4, 1'b0);
    step("add_t5", 1, T5, 8'h1A, ADD5, 1'b0);
    step("add_t6", 1, T6, 8'h1A, ADD6, 1'b0);
    fetch(1, 8'h1A, 8'h2A);
    step("sub_t4", 1, T4, 8'h2A, SUB4, 1'b0);
    step("sub_t5", 1, T5, 8'h2A, SUB5, 1'b0);
    step("sub_t6", 1, T6, 8'h2A, SUB6, 1'b0);

    // Reset held for two cycles starting mid-T5 of an ADD.
    fetch(1, 8'h2A, 8'h1A);
    step("add2_t4", 1, T4, 8'h1A, MEM4, 1'b0);
    rst = 1'b1;
    step("add2_t5_in_rst", 1, T5, 8'h1A, ADD5, 1'b0);
    run = 1'b0;
    step("rst_second_cycle", 1, T1, 8'h00, IDLE, 1'b0);
    rst = 1'b0;
    step("rst_released", 1, T1, 8'h00, IDLE, 1'b0);
    check("reset_t_state_skip", {26'd0, t1s}, {26'd0, T1});
    check("reset_t_state_full", {26'd0, t0s}, {26'd0, T1});
    check("reset_ir_operand", {24'd0, opr1, opr0}, 32'd0);
    check("reset_halted", {30'd0, hlt1, hlt0}, 32'd0);
    check("reset_nla", {30'd0, nLa1, nLa0}, 32'd3);

    // Run gating in T2, then a NOP that skips from T4 back to T1.
    run = 1'b1;
    step("gate_t1", 1, T1, 8'h00, F1, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 3; i++) step("gate_hold_t2", 1, T2, 8'h00, IDLE, 1'b0);
    run = 1'b1;
    step("gate_resume_t2", 1, T2, 8'h00, F2, 1'b0);
    bus_in = 8'h70;
    step("gate_t3", 1, T3, 8'h00, F3, 1'b0);
    bus_in = 8'h00;
    step("nop_skip_t4", 1, T4, 8'h70, IDLE, 1'b0);

    // HLT: ring freezes in T4 with everything inactive until reset.
    fetch(1, 8'h70, 8'hF0);
    step("hlt_t4", 1, T4, 8'hF0, IDLE, 1'b0);
    for (int i = 0; i < 20; i++) step("halted_hold", 1, T4, 8'hF0, IDLE, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0;
    step("hlt_cleared", 1, T1, 8'h00, IDLE, 1'b0);

    // SKIP_IDLE=0: OUT and NOP both occupy all six T-states.
    run = 1'b1;
    fetch(0, 8'h00, 8'hE0);
    step("out_t4", 0, T4, 8'hE0, OUT4, 1'b0);
    step("out_t5", 0, T5, 8'hE0, IDLE, 1'b0);
    step("out_t6", 0, T6, 8'hE0, IDLE, 1'b0);
    fetch(0, 8'hE0, 8'h70);
    step("nop_t4", 0, T4, 8'h70, IDLE, 1'b0);
    step("nop_t5", 0, T5, 8'h70, IDLE, 1'b0);
    step("nop_t6", 0, T6, 8'h70, IDLE, 1'b0);
    step("nop_wrap_t1", 0, T1, 8'h70, F1, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Control unit for the 8-bit bus machine: holds the instruction register (IR) and steps a six-state T-cycle ring counter.
- Decodes each opcode into the per-state control word that drives the program counter, the memory address register (MAR), RAM, IR, accumulator, B register, ALU and output register.
- Sits directly upstream of the accumulator and ALU: it generates nLa, Ea, Eu and sub, and consumes the shared bus only to load the IR.

Parameters:
- SKIP_IDLE, 1, when 1 the ring returns to T1 right after an instruction's last active T-state (LDA/OUT skip T6); when 0 every instruction takes T1..T6.
- OPW, 4, opcode width (IR[7:4]).
- ADW, 4, operand/address width (IR[3:0]).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  step enable; when 0 the T-state, IR and halt state hold and every control output is inactive
- bus_in  in  8  shared bus value, sampled into IR at T3
- ir_operand  out  ADW  IR[3:0], placed on the bus when nEi=0
- t_state  out  6  one-hot T-state, T1 = bit 0
- Cp  out  1  PC increment
- Ep  out  1  PC drives bus
- nLm  out  1  MAR load, active low
- nCE  out  1  RAM drives bus, active low
- nLi  out  1  IR load, active low
- nEi  out  1  IR operand drives bus, active low
- nLa  out  1  accumulator load, active low
- Ea  out  1  accumulator drives bus
- sub  out  1  ALU subtract select
- Eu  out  1  ALU drives bus
- nLb  out  1  B register load, active low
- nLo  out  1  output register load, active low
- halted  out  1  HLT executed

Behaviour:
- Reset (rst=1 at a clock edge):
  - t_state = 000001 (T1), IR = 0x00, halted = 0.
  - All control outputs inactive: Cp=Ep=Ea=sub=Eu=0; nLm=nCE=nLi=nEi=nLa=nLb=nLo=1.
  - Reset overrides run and halt, and aborts any instruction mid-cycle.
- Control outputs are combinational from (t_state, IR, halted, run).
  - They are gated inactive when run=0 or halted=1.
  - There is no pipeline latency: the control word belongs to the current T-state.
- Ring counter advances one state per clock when run=1 and halted=0, and wraps T6 -> T1.
- Fetch, identical for all opcodes:
  - T1: Ep=1, nLm=0.
  - T2: Cp=1.
  - T3: nCE=0, nLi=0. IR <= bus_in at the end of T3.
- Opcodes (IR[7:4]):
  - LDA 0000: T4 nLm=0, nEi=0; T5 nCE=0, nLa=0; T6 none.
  - ADD 0001: T4 nLm=0, nEi=0; T5 nCE=0, nLb=0; T6 Eu=1, nLa=0.
  - SUB 0010: as ADD, with sub=1 during T4..T6.
  - OUT 1110: T4 Ea=1, nLo=0; T5 and T6 none.
  - HLT 1111: in T4, halted is set at the clock edge. The ring freezes at T4 and all controls stay inactive until rst.
  - Any other opcode: NOP; T4..T6 all inactive.
- SKIP_IDLE=1:
  - LDA moves T5 -> T1.
  - OUT and NOP move T4 -> T1.
  - ADD and SUB always run to T6.
- Simultaneous events:
  - rst with run=0: reset still applies.
  - run falling mid-instruction: freezes in place and resumes from the same T-state, IR unchanged.
- ir_operand always reflects IR[3:0], independent of nEi.

Decomposition:
- Package sap_pkg holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - T-state one-hot constants T1..T6;
  - a packed control-word struct {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, sub, Eu, nLb, nLo};
  - the constant CW_IDLE (all inactive).
- One natural sub-module: sap_ring_counter.
  - Inputs: clk, rst, advance, restart.
  - Output: one-hot T-state with wrap.
- IR, halt flag and microcode decode live in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles mid-T5 of an ADD, then release -> t_state=000001, IR=0x00, all control outputs at their inactive levels, including nLa=1.
- Fetch+LDA: run=1, bus_in=0x09 at T3 -> IR=0x09, ir_operand=9.
  - T4: nLm=0, nEi=0. T5: nCE=0, nLa=0.
  - SKIP_IDLE=1: next state is T1 (5 cycles total).
- ADD/SUB: bus_in=0x1A -> T6 has Eu=1, nLa=0, sub=0. bus_in=0x2A -> sub=1 during T4..T6, Eu=1 and nLa=0 in T6, 6 cycles total.
- OUT and NOP with SKIP_IDLE=0:
  - bus_in=0xE0 -> T4 has Ea=1, nLo=0; T5 and T6 inactive; wraps to T1 after 6 cycles.
  - bus_in=0x70 -> T4..T6 all inactive.
- HLT: bus_in=0xF0 -> halted=1 after the T4 edge; t_state stays 001000 and controls stay inactive for 20 cycles; rst clears halted.
- run gating: drop run during T2 for 3 cycles -> Cp=0 and t_state stuck at T2; on run=1, Cp=1 for exactly one cycle, then T3.
